pipe_if: RTL and testbench
==========================

# pipe_if

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of `pipe_id`. Holds the PC, presents it to the combinational-read instruction ROM, and registers the fetched word into the IF/ID pipeline register. Honours load-use stalls from the hazard unit and redirects from EX. Stops fetching after an EBREAK so simulation benches can detect program end.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `HALT_ON_EBREAK`, 1: when 1, fetching EBREAK (32'h0010_0073) enters HALT; when 0, EBREAK is fetched like any other word.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold; freezes PC and IF/ID.
- `redirect_valid`  in  1  EX-resolved control transfer or mispredict.
- `redirect_pc`  in  32  new fetch address, valid with `redirect_valid`.
- `imem_addr`  out  32  current PC, driven combinationally from the PC register.
- `imem_rdata`  in  32  ROM word at `imem_addr`, same cycle.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  32  PC of `if_id_instr`.
- `if_id_instr`  out  32  fetched instruction; NOP (32'h0000_0013) when invalid.
- `if_id_pred_taken`  out  1  IF predicted this instruction taken.
- `halted`  out  1  FSM is in HALT.
- `fetch_count`  out  32  number of instructions written into IF/ID since reset.

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Per-edge priority: `rst` > `redirect_valid` > HALT > `stall` > normal fetch.
- Reset: PC=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=NOP, `if_id_pc`=0, `if_id_pred_taken`=0, `halted`=0, `fetch_count`=0.
- Redirect, in any state and regardless of `stall`:
  - PC=`{redirect_pc[31:2],2'b00}`; low bits are silently cleared.
  - IF/ID becomes a bubble (valid=0, instr=NOP, pred_taken=0).
  - State=RUN. `fetch_count` does not increment.
- Stall in RUN: PC, IF/ID and `fetch_count` hold.
- Normal fetch in RUN:
  - IF/ID receives {1, PC, `imem_rdata`, pred}.
  - PC receives next_pc.
  - `fetch_count` increments and wraps modulo 2^32.
- next_pc is PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), unless prediction applies (see Configuration).
- EBREAK fetched in RUN with `HALT_ON_EBREAK`=1:
  - EBREAK is still written into IF/ID with valid=1.
  - PC holds at the EBREAK address. State=HALT.
- HALT:
  - PC holds. `fetch_count` holds.
  - IF/ID loads a bubble every cycle unless `stall` is high; while `stall` is high, IF/ID holds so ID keeps the EBREAK.
  - `halted`=1.
  - Only `redirect_valid` or `rst` leaves HALT. This covers an older mispredicted branch that makes the EBREAK speculative.
- ECALL is not special.

## Timing
- Fetch latency: the word at PC appears on `if_id_*` one edge after PC is presented. Throughput is one instruction per cycle.
- Redirect penalty:
  - Assert `redirect_valid` in cycle n.
  - Bubble on `if_id_*` in cycle n+1.
  - Target instruction on `if_id_*` in cycle n+2.
- `stall` and `redirect_valid` both high: redirect wins.
- Reset released in cycle n: the word at `RESET_PC` is valid on IF/ID in cycle n+1.
- `imem_addr` changes only after clock edges; `imem_rdata` must settle within the same cycle.

## Configuration
- `PIPE_IF_BTFN_EN` defined: static backward-taken/forward-not-taken prediction on `imem_rdata` in RUN.
  - Opcode 7'b1101111 (JAL): next_pc=PC+imm_J, pred=1.
  - Opcode 7'b1100011 (branch) with instr[31]=1: next_pc=PC+imm_B, pred=1.
  - Otherwise next_pc=PC+4, pred=0.
  - Adder arithmetic is modulo 2^32. EX uses `if_id_pred_taken` to detect mispredicts.
- Macro undefined: next_pc is always PC+4; `if_id_pred_taken` is tied to 0; no predecode logic is synthesised.

## Structure
- Shared package `rv_pipe_pkg` holds:
  - NOP and EBREAK encodings.
  - Opcode constants OP_JAL and OP_BRANCH.
  - FSM state encoding, also used by the bench.
- Sub-module `if_predecode`, combinational: from instr and PC it produces pred_taken and target. It is instantiated only under `PIPE_IF_BTFN_EN`.

## Test plan
- Reset release, ROM words 0..3 = addi x1..x4: `if_id_pc` = 0,4,8,C on consecutive cycles with valid=1; `fetch_count`=4 after 4 fetches.
- `stall` high 2 cycles while IF/ID holds PC 8: `if_id_pc` stays 8, `imem_addr` stays C, `fetch_count` frozen; fetch resumes at C.
- `redirect_valid`=1, `redirect_pc`=32'h40 together with `stall`=1: next cycle bubble (valid=0, instr=13); following cycle `if_id_pc`=40.
- EBREAK at 0x10: IF/ID valid with 32'h0010_0073; `halted`=1 and bubbles thereafter; `imem_addr` stays 0x10. A later redirect to 0x20 clears `halted` and fetches 0x20.
- PC at FFFF_FFFC, non-branch word: next `imem_addr`=0.
- Macro on, `beq` with imm=-8 at 0x30: `if_id_pred_taken`=1 and next `imem_addr`=0x28. Forward `beq` +8: pred=0 and `imem_addr`=0x34. Macro off: pred=0 in both cases.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the RV32I pipeline: canonical NOP/EBREAK words,
// opcodes seen by fetch predecode, and the fetch FSM state type.
package rv_pipe_pkg;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } if_state_e;

endpackage

// File: rtl/pipe_if_predecode.sv
// Static BTFN predecode for the fetch stage (module if_predecode).
// Only compiled when PIPE_IF_BTFN_EN is defined.
`ifdef PIPE_IF_BTFN_EN
module if_predecode
  import rv_pipe_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] target
);

  logic signed [31:0] imm_j;
  logic signed [31:0] imm_b;

  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    target     = pc + 32'd4;
    if (instr[6:0] == OP_JAL) begin
      pred_taken = 1'b1;
      target     = pc + $unsigned(imm_j);
    end else if (instr[6:0] == OP_BRANCH && instr[31]) begin
      // Sign bit set means a backward branch: predict taken.
      pred_taken = 1'b1;
      target     = pc + $unsigned(imm_b);
    end
  end

endmodule
`endif

// File: rtl/pipe_if.sv
// RV32I instruction-fetch stage: PC register, IF/ID register, RUN/HALT FSM.
// Define PIPE_IF_BTFN_EN to enable static backward-taken branch prediction.
module pipe_if
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_pred_taken,
  output logic        halted,
  output logic [31:0] fetch_count
);

  if_state_e   state, state_nxt;
  logic [31:0] pc_p0;
  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic        pred_p1;
  logic [31:0] count;
  logic [31:0] next_pc;
  logic        pred;
  logic        is_ebreak;

`ifdef PIPE_IF_BTFN_EN
  if_predecode u_predecode (
    .instr      (imem_rdata),
    .pc         (pc_p0),
    .pred_taken (pred),
    .target     (next_pc)
  );
`else
  assign pred    = 1'b0;
  assign next_pc = pc_p0 + 32'd4;
`endif

  assign is_ebreak = HALT_ON_EBREAK && (imem_rdata == EBREAK);

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN && !stall && is_ebreak) begin
      state_nxt = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Stage p0 -> p1: PC update and IF/ID register load
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      pc_p1    <= 32'd0;
      instr_p1 <= NOP;
      pred_p1  <= 1'b0;
      count    <= 32'd0;
    end else if (redirect_valid) begin
      pc_p0    <= {redirect_pc[31:2], 2'b00};
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
      pred_p1  <= 1'b0;
    end else if (state == ST_HALT) begin
      // Stall keeps the EBREAK visible to ID; otherwise drain with bubbles.
      if (!stall) begin
        vld_p1   <= 1'b0;
        instr_p1 <= NOP;
        pred_p1  <= 1'b0;
      end
    end else if (!stall) begin
      vld_p1   <= 1'b1;
      pc_p1    <= pc_p0;
      instr_p1 <= imem_rdata;
      pred_p1  <= pred;
      count    <= count + 32'd1;
      if (!is_ebreak) pc_p0 <= next_pc;
    end
  end

  assign imem_addr        = pc_p0;
  assign if_id_valid      = vld_p1;
  assign if_id_pc         = pc_p1;
  assign if_id_instr      = instr_p1;
  assign if_id_pred_taken = pred_p1;
  assign halted           = (state == ST_HALT);
  assign fetch_count      = count;

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: table of per-cycle vectors plus hand sequences
// for PC wrap and branch prediction (expectations follow PIPE_IF_BTFN_EN).
module tb_pipe_if;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, if_id_pred_taken, halted;
  logic [31:0] if_id_pc, if_id_instr, fetch_count;

  logic [31:0] rom [0:63];
  assign imem_rdata = rom[imem_addr[7:2]];

  always #5 clk = ~clk;

  pipe_if dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_pred_taken (if_id_pred_taken),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_pred;
    if_state_e   e_st;
    logic [31:0] e_addr, e_count;
  } vec_t;

  vec_t tbl [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] w(input int i);
    return {i[11:0], 20'h00093};  // addi x1, x0, i
  endfunction

  function automatic vec_t mk(input logic r, s, v, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, ei,
                              input logic ep, input if_state_e st,
                              input logic [31:0] ea, ec);
    vec_t t;
    t.rst = r; t.stall = s; t.rv = v; t.rpc = rpc;
    t.e_valid = ev; t.e_pc = epc; t.e_instr = ei; t.e_pred = ep;
    t.e_st = st; t.e_addr = ea; t.e_count = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, s, v, input logic [31:0] p);
    rst = r; stall = s; redirect_valid = v; redirect_pc = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        exp_pred;

    for (int i = 0; i < 64; i++) rom[i] = w(i);
    rom[4] = 32'h0010_0073;  // EBREAK at 0x10
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    //            rst stl rv rpc           vld pc            instr          prd state    addr          count
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h13,        0, ST_RUN,  32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        w(0),          0, ST_RUN,  32'h4,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        w(1),          0, ST_RUN,  32'h8,        2));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h8,        w(2),          0, ST_RUN,  32'hC,        3));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8,        w(2),          0, ST_RUN,  32'hC,        3));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8,        w(2),          0, ST_RUN,  32'hC,        3));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        w(3),          0, ST_RUN,  32'h10,       4));
    tbl.push_back(mk(0, 1, 1, 32'h43,       0, 32'h0,        32'h13,        0, ST_RUN,  32'h40,       4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h40,       w(16),         0, ST_RUN,  32'h44,       5));
    tbl.push_back(mk(0, 0, 1, 32'h10,       0, 32'h0,        32'h13,        0, ST_RUN,  32'h10,       5));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       32'h0010_0073, 0, ST_HALT, 32'h10,       6));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10,       32'h0010_0073, 0, ST_HALT, 32'h10,       6));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h13,        0, ST_HALT, 32'h10,       6));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h13,        0, ST_HALT, 32'h10,       6));
    tbl.push_back(mk(0, 0, 1, 32'h20,       0, 32'h0,        32'h13,        0, ST_RUN,  32'h20,       6));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h20,       w(8),          0, ST_RUN,  32'h24,       7));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc);
      check($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid || tbl[i].rst)
        check($sformatf("v%0d pc", i), if_id_pc, tbl[i].e_pc);
      check($sformatf("v%0d instr", i), if_id_instr, tbl[i].e_instr);
      check($sformatf("v%0d pred", i), {31'd0, if_id_pred_taken}, {31'd0, tbl[i].e_pred});
      check($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, tbl[i].e_st == ST_HALT});
      check($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("v%0d count", i), fetch_count, tbl[i].e_count);
    end

    // PC wrap from the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap redirect addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    check("wrap valid", {31'd0, if_id_valid}, 32'd1);
    check("wrap pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap instr", if_id_instr, w(63));
    check("wrap addr", imem_addr, 32'h0);
    check("wrap count", fetch_count, 32'd8);

    // Backward beq x0,x0,-8 at 0x30
`ifdef PIPE_IF_BTFN_EN
    exp_pred = 1'b1; exp_addr = 32'h28;
`else
    exp_pred = 1'b0; exp_addr = 32'h34;
`endif
    rom[12] = 32'hFE00_0CE3;
    step(0, 0, 1, 32'h30);
    check("bwd redirect addr", imem_addr, 32'h30);
    step(0, 0, 0, 32'h0);
    check("bwd instr", if_id_instr, 32'hFE00_0CE3);
    check("bwd pred", {31'd0, if_id_pred_taken}, {31'd0, exp_pred});
    check("bwd next addr", imem_addr, exp_addr);
    check("bwd count", fetch_count, 32'd9);

    // Forward beq x0,x0,+8 at 0x30: never predicted
    rom[12] = 32'h0000_0463;
    step(0, 0, 1, 32'h30);
    check("fwd redirect pred", {31'd0, if_id_pred_taken}, 32'd0);
    step(0, 0, 0, 32'h0);
    check("fwd pc", if_id_pc, 32'h30);
    check("fwd pred", {31'd0, if_id_pred_taken}, 32'd0);
    check("fwd next addr", imem_addr, 32'h34);
    check("fwd count", fetch_count, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
